// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake plus data-memory bus for the
// load/store unit. The slave modport is the unit's view; the master modport is
// the view of whatever sits around it (pipeline + memory).
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both high. req_* fields must be stable from the preceding
// falling edge. rsp_valid is a one-cycle pulse and rsp_rdata/rsp_err are only
// meaningful while it is high. The requester does not stall the response.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_word;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;

  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;

  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic        mem_bh;
  logic [15:0] mem_rdata;

  // Current FSM state, exposed for checkers and waveform debug.
  logic [2:0]  dbg_state;

  modport slave (
    input  req_valid, req_write, req_word, req_signed, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall,
    output mem_addr, mem_wdata, mem_read, mem_write, mem_bh,
    output dbg_state
  );

  modport master (
    output req_valid, req_write, req_word, req_signed, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall,
    input  mem_addr, mem_wdata, mem_read, mem_write, mem_bh,
    input  dbg_state
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store engine between the MEM-stage
// register and a byte-addressable data memory. Byte loads are sign/zero
// extended to 16 bits. Out-of-range requests are answered with rsp_err.
//
// Build option: define LSU_MISALIGN_SPLIT_EN to perform odd-address word
// accesses as two byte accesses (SPLIT_LO then SPLIT_HI). Without it such
// accesses are rejected with rsp_err and never touch the memory.
module load_store_unit #(
  parameter int ADDR_LIMIT = 64
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);

`ifdef LSU_MISALIGN_SPLIT_EN
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ACCESS   = 3'd1,
    S_SPLIT_LO = 3'd2,
    S_SPLIT_HI = 3'd3,
    S_ERR      = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_ERR    = 3'd4
  } state_e;
`endif

  // Highest legal start address for a byte and for a word access. Widened by
  // one bit so the comparison stays unsigned and cannot wrap.
  localparam logic [16:0] BYTE_MAX = 17'(ADDR_LIMIT - 1);
  localparam logic [16:0] WORD_MAX = 17'(ADDR_LIMIT - 2);

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic        word_q, word_d;
  logic        signed_q, signed_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [7:0]  lo_q, lo_d;
`endif

  logic        out_of_range;
  logic [15:0] mem_addr_c;
  logic [15:0] mem_wdata_c;
  logic        mem_read_c;
  logic        mem_write_c;
  logic        mem_bh_c;

  function automatic logic [15:0] byte_ext(input logic [7:0] b, input logic sgn);
    return {{8{sgn & b[7]}}, b};
  endfunction

  // Range check of the incoming request, done before any address arithmetic.
  always_comb begin
    out_of_range = 1'b0;
    if (bus.req_word) out_of_range = ({1'b0, bus.req_addr} > WORD_MAX);
    else              out_of_range = ({1'b0, bus.req_addr} > BYTE_MAX);
  end

  // Next-state, request latching, memory strobes and response generation.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    word_d      = word_q;
    signed_d    = signed_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 16'h0000;
    rsp_err_d   = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
    lo_d        = lo_q;
`endif
    mem_addr_c  = 16'h0000;
    mem_wdata_c = 16'h0000;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    mem_bh_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          word_d   = bus.req_word;
          signed_d = bus.req_signed;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          if (out_of_range) begin
            state_d = S_ERR;
          end else if (bus.req_word && bus.req_addr[0]) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            state_d = S_SPLIT_LO;
`else
            state_d = S_ERR;
`endif
          end else begin
            state_d = S_ACCESS;
          end
        end
      end

      S_ACCESS: begin
        mem_addr_c  = addr_q;
        mem_wdata_c = wdata_q;
        mem_bh_c    = word_q;
        mem_read_c  = ~write_q;
        mem_write_c = write_q;
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        if (!write_q) begin
          if (word_q) rsp_rdata_d = bus.mem_rdata;
          else        rsp_rdata_d = byte_ext(bus.mem_rdata[7:0], signed_q);
        end
      end

`ifdef LSU_MISALIGN_SPLIT_EN
      S_SPLIT_LO: begin
        mem_addr_c  = addr_q;
        mem_wdata_c = {8'h00, wdata_q[7:0]};
        mem_read_c  = ~write_q;
        mem_write_c = write_q;
        lo_d        = bus.mem_rdata[7:0];
        state_d     = S_SPLIT_HI;
      end

      S_SPLIT_HI: begin
        // addr_q passed the word range check, so addr_q+1 cannot wrap.
        mem_addr_c  = addr_q + 16'd1;
        mem_wdata_c = {8'h00, wdata_q[15:8]};
        mem_read_c  = ~write_q;
        mem_write_c = write_q;
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        if (!write_q) rsp_rdata_d = {bus.mem_rdata[7:0], lo_q};
      end
`endif

      S_ERR: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      word_q      <= 1'b0;
      signed_q    <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      rsp_err_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      lo_q        <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      word_q      <= word_d;
      signed_q    <= signed_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      lo_q        <= lo_d;
`endif
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.stall     = bus.req_valid & ~bus.req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.mem_read  = mem_read_c;
  assign bus.mem_write = mem_write_c;
  assign bus.mem_bh    = mem_bh_c;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit
// against a transaction-level model of a byte-addressed memory.
module tb_load_store_unit;
  localparam int ADDR_LIMIT = 64;
  localparam int AW = $clog2(ADDR_LIMIT);
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] rd;
    logic        er;
    int          lat;
    int          n_wr;
    int          n_rd;
    int          n_bh;
    logic [15:0] a0;
    logic [15:0] d0;
    logic [15:0] a1;
    logic [15:0] d1;
  } obs_t;

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit #(.ADDR_LIMIT(ADDR_LIMIT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // ---------------- data memory ----------------
  logic [7:0] tb_mem [ADDR_LIMIT];
  logic [7:0] ref_mem [ADDR_LIMIT];
  logic       mem_loaded = 1'b0;

  always_comb begin
    bus.mem_rdata = 16'h0000;
    if (int'(bus.mem_addr) < ADDR_LIMIT)
      bus.mem_rdata[7:0] = tb_mem[bus.mem_addr[AW-1:0]];
    if (int'(bus.mem_addr) + 1 < ADDR_LIMIT)
      bus.mem_rdata[15:8] = tb_mem[bus.mem_addr[AW-1:0] + AW'(1)];
  end

  always @(negedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < ADDR_LIMIT; i++) tb_mem[i] <= 8'((i * 37 + 11) & 255);
      mem_loaded <= 1'b1;
    end else if (bus.mem_write) begin
      if (int'(bus.mem_addr) < ADDR_LIMIT)
        tb_mem[bus.mem_addr[AW-1:0]] <= bus.mem_wdata[7:0];
      if (bus.mem_bh && int'(bus.mem_addr) + 1 < ADDR_LIMIT)
        tb_mem[bus.mem_addr[AW-1:0] + AW'(1)] <= bus.mem_wdata[15:8];
    end
  end

  // ---------------- reference model ----------------
  function automatic void model(input logic w, input logic wd, input logic sg,
                                input logic [15:0] a, input logic [15:0] d,
                                output obs_t e);
    int  ai;
    logic oor, mis;
    logic [7:0] b;
    ai  = int'(a);
    oor = wd ? (ai > ADDR_LIMIT - 2) : (ai > ADDR_LIMIT - 1);
    mis = wd & a[0];
    e = '{rd: 16'h0, er: 1'b0, lat: 2, n_wr: 0, n_rd: 0, n_bh: 0,
          a0: 16'h0, d0: 16'h0, a1: 16'h0, d1: 16'h0};
    if (oor || (mis && !SPLIT_EN)) begin
      e.er = 1'b1;
      return;
    end
    e.lat  = mis ? 3 : 2;
    e.n_bh = (wd && !mis) ? 1 : 0;
    if (w) begin
      e.n_wr = mis ? 2 : 1;
      ref_mem[ai] = d[7:0];
      if (wd) ref_mem[ai + 1] = d[15:8];
    end else begin
      e.n_rd = mis ? 2 : 1;
      b = ref_mem[ai];
      if (wd)      e.rd = {ref_mem[ai + 1], b};
      else if (sg) e.rd = {{8{b[7]}}, b};
      else         e.rd = {8'h00, b};
    end
  endfunction

  // ---------------- driver ----------------
  task automatic drive_req(input logic w, input logic wd, input logic sg,
                           input logic [15:0] a, input logic [15:0] d, output obs_t o);
    o = '{rd: 16'h0, er: 1'b0, lat: 0, n_wr: 0, n_rd: 0, n_bh: 0,
          a0: 16'h0, d0: 16'h0, a1: 16'h0, d1: 16'h0};
    @(negedge clk);
    bus.req_write  = w;
    bus.req_word   = wd;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        o.lat = i;
        o.rd  = bus.rsp_rdata;
        o.er  = bus.rsp_err;
        break;
      end
      if (i == 1) begin o.a0 = bus.mem_addr; o.d0 = bus.mem_wdata; end
      if (i == 2) begin o.a1 = bus.mem_addr; o.d1 = bus.mem_wdata; end
      o.n_wr += int'(bus.mem_write);
      o.n_rd += int'(bus.mem_read);
      o.n_bh += int'(bus.mem_bh);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got=%0b exp=1", bus.req_ready); end
    tests_run++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 16'h0) begin tests_failed++; $display("FAIL reset_rsp got v=%0b e=%0b d=%h exp 0/0/0000", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    tests_run++; if (bus.stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got=%0b exp=0", bus.stall); end
    tests_run++; if ({bus.mem_read, bus.mem_write, bus.mem_bh, bus.mem_addr, bus.mem_wdata} !== 35'h0) begin tests_failed++; $display("FAIL reset_mem got rd=%0b wr=%0b bh=%0b a=%h d=%h exp all 0", bus.mem_read, bus.mem_write, bus.mem_bh, bus.mem_addr, bus.mem_wdata); end
  endtask

  task automatic test_word_store_load;
    obs_t o, e;
    model(1'b1, 1'b1, 1'b0, 16'h0010, 16'hBEEF, e);
    drive_req(1'b1, 1'b1, 1'b0, 16'h0010, 16'hBEEF, o);
    tests_run++; if (o.lat !== 2 || o.er !== 1'b0) begin tests_failed++; $display("FAIL wst_lat got lat=%0d err=%0b exp lat=2 err=0", o.lat, o.er); end
    tests_run++; if (o.n_wr !== 1 || o.n_bh !== 1 || o.n_rd !== 0) begin tests_failed++; $display("FAIL wst_strobes got wr=%0d bh=%0d rd=%0d exp 1/1/0", o.n_wr, o.n_bh, o.n_rd); end
    tests_run++; if (o.a0 !== 16'h0010 || o.d0 !== 16'hBEEF) begin tests_failed++; $display("FAIL wst_bus got a=%h d=%h exp 0010/beef", o.a0, o.d0); end
    tests_run++; if ({tb_mem[16'h11], tb_mem[16'h10]} !== 16'hBEEF) begin tests_failed++; $display("FAIL wst_mem got %h exp beef", {tb_mem[16'h11], tb_mem[16'h10]}); end
    model(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0, e);
    drive_req(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0, o);
    tests_run++; if (o.rd !== 16'hBEEF || o.lat !== 2) begin tests_failed++; $display("FAIL wld_data got d=%h lat=%0d exp beef lat=2", o.rd, o.lat); end
  endtask

  task automatic test_byte_loads;
    obs_t o, e;
    model(1'b1, 1'b0, 1'b0, 16'h0005, 16'h779C, e);
    drive_req(1'b1, 1'b0, 1'b0, 16'h0005, 16'h779C, o);
    tests_run++; if (tb_mem[5] !== 8'h9C || o.n_bh !== 0) begin tests_failed++; $display("FAIL bst_mem got %h bh=%0d exp 9c bh=0", tb_mem[5], o.n_bh); end
    model(1'b0, 1'b0, 1'b1, 16'h0005, 16'h0, e);
    drive_req(1'b0, 1'b0, 1'b1, 16'h0005, 16'h0, o);
    tests_run++; if (o.rd !== 16'hFF9C) begin tests_failed++; $display("FAIL bld_signed got %h exp ff9c", o.rd); end
    model(1'b0, 1'b0, 1'b0, 16'h0005, 16'h0, e);
    drive_req(1'b0, 1'b0, 1'b0, 16'h0005, 16'h0, o);
    tests_run++; if (o.rd !== 16'h009C) begin tests_failed++; $display("FAIL bld_unsigned got %h exp 009c", o.rd); end
  endtask

  task automatic test_misaligned;
    obs_t o, e;
    logic [7:0] b21, b22;
    b21 = ref_mem[16'h21];
    b22 = ref_mem[16'h22];
    model(1'b1, 1'b1, 1'b0, 16'h0021, 16'h1234, e);
    drive_req(1'b1, 1'b1, 1'b0, 16'h0021, 16'h1234, o);
`ifdef LSU_MISALIGN_SPLIT_EN
    tests_run++; if (o.lat !== 3 || o.er !== 1'b0 || o.n_wr !== 2 || o.n_bh !== 0) begin tests_failed++; $display("FAIL mis_st got lat=%0d err=%0b wr=%0d bh=%0d exp 3/0/2/0", o.lat, o.er, o.n_wr, o.n_bh); end
    tests_run++; if (o.a0 !== 16'h0021 || o.d0 !== 16'h0034 || o.a1 !== 16'h0022 || o.d1 !== 16'h0012) begin tests_failed++; $display("FAIL mis_bus got %h:%h %h:%h exp 0021:0034 0022:0012", o.a0, o.d0, o.a1, o.d1); end
    tests_run++; if (tb_mem[16'h21] !== 8'h34 || tb_mem[16'h22] !== 8'h12) begin tests_failed++; $display("FAIL mis_mem got %h %h exp 34 12", tb_mem[16'h21], tb_mem[16'h22]); end
    model(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0, e);
    drive_req(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0, o);
    tests_run++; if (o.rd !== 16'h1234 || o.lat !== 3 || o.n_rd !== 2) begin tests_failed++; $display("FAIL mis_ld got d=%h lat=%0d rd=%0d exp 1234/3/2", o.rd, o.lat, o.n_rd); end
`else
    tests_run++; if (o.er !== 1'b1 || o.rd !== 16'h0 || o.lat !== 2 || o.n_wr !== 0) begin tests_failed++; $display("FAIL mis_st got err=%0b d=%h lat=%0d wr=%0d exp 1/0000/2/0", o.er, o.rd, o.lat, o.n_wr); end
    tests_run++; if (tb_mem[16'h21] !== b21 || tb_mem[16'h22] !== b22) begin tests_failed++; $display("FAIL mis_mem got %h %h exp %h %h", tb_mem[16'h21], tb_mem[16'h22], b21, b22); end
    model(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0, e);
    drive_req(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0, o);
    tests_run++; if (o.er !== 1'b1 || o.rd !== 16'h0 || o.n_rd !== 0) begin tests_failed++; $display("FAIL mis_ld got err=%0b d=%h rd=%0d exp 1/0000/0", o.er, o.rd, o.n_rd); end
`endif
  endtask

  task automatic test_range;
    obs_t o, e;
    drive_req(1'b0, 1'b1, 1'b0, 16'h003F, 16'h0, o);
    model(1'b0, 1'b1, 1'b0, 16'h003F, 16'h0, e);
    tests_run++; if (o.er !== 1'b1 || o.rd !== 16'h0 || o.lat !== 2 || o.n_rd !== 0) begin tests_failed++; $display("FAIL rng_word3f got err=%0b d=%h lat=%0d rd=%0d exp 1/0000/2/0", o.er, o.rd, o.lat, o.n_rd); end
    model(1'b0, 1'b0, 1'b0, 16'h003F, 16'h0, e);
    drive_req(1'b0, 1'b0, 1'b0, 16'h003F, 16'h0, o);
    tests_run++; if (o.er !== 1'b0 || o.rd !== e.rd) begin tests_failed++; $display("FAIL rng_byte3f got err=%0b d=%h exp 0/%h", o.er, o.rd, e.rd); end
    model(1'b0, 1'b1, 1'b0, 16'h003E, 16'h0, e);
    drive_req(1'b0, 1'b1, 1'b0, 16'h003E, 16'h0, o);
    tests_run++; if (o.er !== 1'b0 || o.rd !== e.rd) begin tests_failed++; $display("FAIL rng_word3e got err=%0b d=%h exp 0/%h", o.er, o.rd, e.rd); end
    model(1'b1, 1'b0, 1'b0, 16'h0040, 16'h00AA, e);
    drive_req(1'b1, 1'b0, 1'b0, 16'h0040, 16'h00AA, o);
    tests_run++; if (o.er !== 1'b1 || o.n_wr !== 0) begin tests_failed++; $display("FAIL rng_byte40 got err=%0b wr=%0d exp 1/0", o.er, o.n_wr); end
    model(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h5555, e);
    drive_req(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h5555, o);
    tests_run++; if (o.er !== 1'b1 || o.n_wr !== 0 || o.lat !== 2) begin tests_failed++; $display("FAIL rng_ffff got err=%0b wr=%0d lat=%0d exp 1/0/2", o.er, o.n_wr, o.lat); end
  endtask

  task automatic test_back_to_back;
    obs_t e;
    logic [15:0] exp_q[$];
    logic [15:0] want;
    logic exp_stall, exp_rsp;
    for (int r = 0; r < 3; r++) begin
      model(1'b0, 1'b0, 1'b0, 16'(r + 1), 16'h0, e);
      exp_q.push_back(e.rd);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_stall = (k == 1 || k == 3 || k == 5);
      exp_rsp   = (k == 2 || k == 4 || k == 6);
      tests_run++; if (bus.stall !== exp_stall) begin tests_failed++; $display("FAIL b2b_stall k=%0d got=%0b exp=%0b", k, bus.stall, exp_stall); end
      tests_run++; if (bus.rsp_valid !== exp_rsp) begin tests_failed++; $display("FAIL b2b_rsp k=%0d got=%0b exp=%0b", k, bus.rsp_valid, exp_rsp); end
      if (exp_rsp && exp_q.size() > 0) begin
        want = exp_q.pop_front();
        tests_run++; if (bus.rsp_rdata !== want) begin tests_failed++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, bus.rsp_rdata, want); end
      end
      if (k < 6 && (k % 2) == 0) begin
        bus.req_write  = 1'b0;
        bus.req_word   = 1'b0;
        bus.req_signed = 1'b0;
        bus.req_addr   = 16'(k / 2 + 1);
        bus.req_valid  = 1'b1;
      end else if (k == 6) begin
        bus.req_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_op;
    logic [7:0] pre8;
    int seen;
    // Reset in the ACCESS cycle of a byte store, before the memory's falling edge.
    pre8 = ref_mem[8];
    @(negedge clk);
    bus.req_write = 1'b1; bus.req_word = 1'b0; bus.req_signed = 1'b0;
    bus.req_addr = 16'h0008; bus.req_wdata = 16'h0077; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    tests_run++; if ({bus.mem_read, bus.mem_write, bus.mem_bh, bus.mem_addr, bus.mem_wdata} !== 35'h0 || bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_acc_out got wr=%0b a=%h d=%h rdy=%0b exp 0/0000/0000/1", bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.req_ready); end
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    seen = 0;
    repeat (3) begin @(negedge clk); seen += int'(bus.rsp_valid); end
    tests_run++; if (seen !== 0 || tb_mem[8] !== pre8) begin tests_failed++; $display("FAIL rst_acc_after got rsp=%0d mem=%h exp 0/%h", seen, tb_mem[8], pre8); end
`ifdef LSU_MISALIGN_SPLIT_EN
    // Reset in SPLIT_HI of a misaligned store: low byte stays written.
    pre8 = ref_mem[16'h32];
    @(negedge clk);
    bus.req_write = 1'b1; bus.req_word = 1'b1; bus.req_signed = 1'b0;
    bus.req_addr = 16'h0031; bus.req_wdata = 16'hA55A; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    tests_run++; if (bus.mem_addr !== 16'h0032 || bus.mem_write !== 1'b1) begin tests_failed++; $display("FAIL rst_split_hi got a=%h wr=%0b exp 0032/1", bus.mem_addr, bus.mem_write); end
    reset = 1'b1;
    #1;
    tests_run++; if ({bus.mem_read, bus.mem_write, bus.mem_bh, bus.mem_addr, bus.mem_wdata} !== 35'h0 || bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_split_out got wr=%0b a=%h d=%h v=%0b exp all 0", bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.rsp_valid); end
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    seen = 0;
    repeat (3) begin @(negedge clk); seen += int'(bus.rsp_valid); end
    tests_run++; if (seen !== 0 || tb_mem[16'h31] !== 8'h5A || tb_mem[16'h32] !== pre8) begin tests_failed++; $display("FAIL rst_split_mem got rsp=%0d %h %h exp 0 5a %h", seen, tb_mem[16'h31], tb_mem[16'h32], pre8); end
    ref_mem[16'h31] = 8'h5A;
`endif
  endtask

  task automatic test_random;
    obs_t o, e;
    logic w, wd, sg;
    logic [15:0] a, d;
    for (int n = 0; n < 60; n++) begin
      w  = 1'($urandom_range(0, 1));
      wd = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      a  = 16'($urandom_range(0, ADDR_LIMIT + 3));
      d  = 16'($urandom);
      model(w, wd, sg, a, d, e);
      drive_req(w, wd, sg, a, d, o);
      tests_run++;
      if (o.rd !== e.rd || o.er !== e.er || o.lat !== e.lat || o.n_wr !== e.n_wr || o.n_rd !== e.n_rd || o.n_bh !== e.n_bh) begin
        tests_failed++;
        $display("FAIL rand_%0d w=%0b wd=%0b sg=%0b a=%h got d=%h e=%0b lat=%0d wr=%0d rd=%0d bh=%0d exp d=%h e=%0b lat=%0d wr=%0d rd=%0d bh=%0d",
                 n, w, wd, sg, a, o.rd, o.er, o.lat, o.n_wr, o.n_rd, o.n_bh, e.rd, e.er, e.lat, e.n_wr, e.n_rd, e.n_bh);
      end
    end
  endtask

  task automatic test_memory_image;
    int diffs;
    diffs = 0;
    for (int i = 0; i < ADDR_LIMIT; i++) if (tb_mem[i] !== ref_mem[i]) diffs++;
    tests_run++; if (diffs !== 0) begin tests_failed++; $display("FAIL mem_image got %0d differing bytes exp 0", diffs); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_word   = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 16'h0;
    bus.req_wdata  = 16'h0;
    for (int i = 0; i < ADDR_LIMIT; i++) ref_mem[i] = 8'((i * 37 + 11) & 255);
    test_reset();
    test_word_store_load();
    test_byte_loads();
    test_misaligned();
    test_range();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    test_memory_image();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
